// File: rtl/bp_fe_fetch_queue.sv
// Fetch queue between the realigner and the backend issue path.
// Buffers assembled instructions and tracks the sequential next-PC after the last enqueue.
module bp_fe_fetch_queue
  #(parameter int vaddr_width_p   = 39
    , parameter int instr_width_gp  = 32
    , parameter int cinstr_width_gp = 16
    , parameter int fetch_ptr_gp    = 2
    , parameter int els_p           = 4
    , localparam int lg_els_lp      = $clog2(els_p)
    , localparam int fill_width_lp  = $clog2(els_p+1)
    )
    (input  logic                       clk_i
     , input  logic                     reset_i

     , input  logic                     fetch_instr_v_i
     , input  logic [vaddr_width_p-1:0] fetch_pc_i
     , input  logic [instr_width_gp-1:0] fetch_instr_i
     , input  logic [fetch_ptr_gp-1:0]  fetch_count_i
     , input  logic                     fetch_partial_i
     , output logic                     fetch_ready_then_o

     , input  logic                     flush_i

     , output logic                     issue_v_o
     , output logic [vaddr_width_p-1:0] issue_pc_o
     , output logic [instr_width_gp-1:0] issue_instr_o
     , output logic                     issue_compressed_o
     , output logic [fetch_ptr_gp-1:0]  issue_count_o
     , output logic                     issue_partial_o
     , input  logic                     issue_yumi_i

     , output logic                     empty_o
     , output logic [fill_width_lp-1:0] fill_count_o
     , output logic                     next_pc_v_o
     , output logic [vaddr_width_p-1:0] next_pc_o
     );

    typedef struct packed {
        logic [vaddr_width_p-1:0]  pc;
        logic [instr_width_gp-1:0] instr;
        logic                      compressed;
        logic [fetch_ptr_gp-1:0]   count;
        logic                      partial;
    } entry_t;

    entry_t                     mem_q [els_p];
    entry_t                     entry_d;
    entry_t                     head;

    logic [lg_els_lp-1:0]       rd_ptr_q, rd_ptr_d;
    logic [lg_els_lp-1:0]       wr_ptr_q, wr_ptr_d;
    logic [fill_width_lp-1:0]   fill_q, fill_d;
    logic                       next_pc_v_q, next_pc_v_d;
    logic [vaddr_width_p-1:0]   next_pc_q, next_pc_d;

    logic empty, full, enq, deq, fetch_compressed;

    assign empty = (fill_q == '0);
    assign full  = (fill_q == fill_width_lp'(els_p));

    // Ready depends only on registered occupancy; a same-cycle yumi does not free a slot.
    assign fetch_ready_then_o = ~full;

    assign fetch_compressed = ~&fetch_instr_i[1:0];
    assign enq = fetch_instr_v_i & ~full & ~flush_i;
    assign deq = issue_yumi_i & ~empty & ~flush_i;

    always_comb begin
        entry_d            = '0;
        entry_d.pc         = fetch_pc_i;
        entry_d.instr      = fetch_instr_i;
        entry_d.compressed = fetch_compressed;
        entry_d.count      = fetch_count_i;
        entry_d.partial    = fetch_partial_i;
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        next_pc_v_d = next_pc_v_q;
        next_pc_d   = next_pc_q;

        if (flush_i) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            fill_d      = '0;
            next_pc_v_d = 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_d    = wr_ptr_q + lg_els_lp'(1);
                next_pc_v_d = 1'b1;
                next_pc_d   = fetch_pc_i
                              + (fetch_compressed ? vaddr_width_p'(2) : vaddr_width_p'(4));
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + lg_els_lp'(1);
            end
            if (enq && !deq) begin
                fill_d = fill_q + fill_width_lp'(1);
            end else if (!enq && deq) begin
                fill_d = fill_q - fill_width_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            next_pc_v_q <= 1'b0;
            next_pc_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            next_pc_v_q <= next_pc_v_d;
            next_pc_q   <= next_pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq && !reset_i) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign issue_v_o          = ~empty;
    assign issue_pc_o         = head.pc;
    assign issue_instr_o      = head.compressed
                                ? {{(instr_width_gp-cinstr_width_gp){1'b0}}, head.instr[cinstr_width_gp-1:0]}
                                : head.instr;
    assign issue_compressed_o = head.compressed;
    assign issue_count_o      = head.count;
    assign issue_partial_o    = head.partial;

    assign empty_o      = empty;
    assign fill_count_o = fill_q;
    assign next_pc_v_o  = next_pc_v_q;
    assign next_pc_o    = next_pc_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(fetch_instr_v_i && !fetch_ready_then_o));
            assert (!(issue_yumi_i && !issue_v_o));
        end
    end

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Scoreboard bench for bp_fe_fetch_queue: stimulus pushes expected entries,
// a monitor pops and compares on every accepted issue.
module tb_bp_fe_fetch_queue;

    localparam int VW = 32;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            fetch_instr_v_i;
    logic [VW-1:0]   fetch_pc_i;
    logic [31:0]     fetch_instr_i;
    logic [1:0]      fetch_count_i;
    logic            fetch_partial_i;
    logic            fetch_ready_then_o;
    logic            flush_i;
    logic            issue_v_o;
    logic [VW-1:0]   issue_pc_o;
    logic [31:0]     issue_instr_o;
    logic            issue_compressed_o;
    logic [1:0]      issue_count_o;
    logic            issue_partial_o;
    logic            issue_yumi_i;
    logic            empty_o;
    logic [2:0]      fill_count_o;
    logic            next_pc_v_o;
    logic [VW-1:0]   next_pc_o;

    bp_fe_fetch_queue #(.vaddr_width_p(VW), .els_p(4)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .fetch_instr_v_i    (fetch_instr_v_i),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_instr_i      (fetch_instr_i),
        .fetch_count_i      (fetch_count_i),
        .fetch_partial_i    (fetch_partial_i),
        .fetch_ready_then_o (fetch_ready_then_o),
        .flush_i            (flush_i),
        .issue_v_o          (issue_v_o),
        .issue_pc_o         (issue_pc_o),
        .issue_instr_o      (issue_instr_o),
        .issue_compressed_o (issue_compressed_o),
        .issue_count_o      (issue_count_o),
        .issue_partial_o    (issue_partial_o),
        .issue_yumi_i       (issue_yumi_i),
        .empty_o            (empty_o),
        .fill_count_o       (fill_count_o),
        .next_pc_v_o        (next_pc_v_o),
        .next_pc_o          (next_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VW-1:0] pc;
        logic [31:0]   instr;
        logic          compressed;
        logic [1:0]    count;
        logic          partial;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, between input updates and the active edge.
    always @(negedge clk) begin
        if (!reset_i && !flush_i && issue_v_o) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL spurious_issue: got issue_v_o=1 pc=0x%0h expected no entry", issue_pc_o);
            end else if (issue_yumi_i) begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_pc", 64'(issue_pc_o), 64'(e.pc));
                chk("issue_instr", 64'(issue_instr_o), 64'(e.instr));
                chk("issue_meta", 64'({issue_compressed_o, issue_count_o, issue_partial_o}),
                    64'({e.compressed, e.count, e.partial}));
            end
        end
    end

    task automatic idle();
        fetch_instr_v_i = 1'b0;
        issue_yumi_i    = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; expected entries are hand-supplied by the caller.
    task automatic cyc(input logic v, input logic [VW-1:0] pc, input logic [31:0] instr,
                       input logic [31:0] exp_instr, input logic exp_c,
                       input logic [1:0] cnt, input logic part,
                       input logic yumi, input logic flush);
        exp_t e;
        fetch_instr_v_i = v;
        fetch_pc_i      = pc;
        fetch_instr_i   = instr;
        fetch_count_i   = cnt;
        fetch_partial_i = part;
        issue_yumi_i    = yumi;
        flush_i         = flush;
        if (v && !flush) begin
            e.pc = pc; e.instr = exp_instr; e.compressed = exp_c; e.count = cnt; e.partial = part;
            sb.push_back(e);
        end
        tick();
        idle();
    endtask

    task automatic yumi_cyc();
        cyc(1'b0, '0, '0, '0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        fetch_pc_i = '0; fetch_instr_i = '0; fetch_count_i = '0; fetch_partial_i = 1'b0;
        idle();
        tick(); tick();
        reset_i = 1'b0;

        chk("rst_issue_v", 64'(issue_v_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_fill", 64'(fill_count_o), 64'd0);
        chk("rst_ready", 64'(fetch_ready_then_o), 64'd1);
        chk("rst_next_pc_v", 64'(next_pc_v_o), 64'd0);
        chk("rst_next_pc", 64'(next_pc_o), 64'd0);

        // Aligned 32-bit instruction
        cyc(1'b1, 32'h8000_0000, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("a32_issue_v", 64'(issue_v_o), 64'd1);
        chk("a32_compressed", 64'(issue_compressed_o), 64'd0);
        chk("a32_next_pc", 64'(next_pc_o), 64'h8000_0004);
        chk("a32_next_pc_v", 64'(next_pc_v_o), 64'd1);
        yumi_cyc();
        chk("a32_empty_after", 64'(empty_o), 64'd1);
        chk("a32_next_pc_hold", 64'(next_pc_o), 64'h8000_0004);

        // Compressed: upper half is garbage on input, zero on output
        cyc(1'b1, 32'h8000_0006, 32'hABCD_4501, 32'h0000_4501, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("c16_instr", 64'(issue_instr_o), 64'h0000_4501);
        chk("c16_compressed", 64'(issue_compressed_o), 64'd1);
        chk("c16_next_pc", 64'(next_pc_o), 64'h8000_0008);
        yumi_cyc();

        // Fill to capacity; pointers start at 2 so storage wraps
        cyc(1'b1, 32'h0000_0100, 32'h0010_0093, 32'h0010_0093, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0104, 32'h0020_0113, 32'h0020_0113, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0108, 32'h0000_0085, 32'h0000_0085, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_010A, 32'h0030_0193, 32'h0030_0193, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("full_fill", 64'(fill_count_o), 64'd4);
        chk("full_ready", 64'(fetch_ready_then_o), 64'd0);
        chk("full_next_pc", 64'(next_pc_o), 64'h0000_010E);
        issue_yumi_i = 1'b1;
        chk("full_ready_with_yumi", 64'(fetch_ready_then_o), 64'd0);
        tick(); idle();
        chk("after_yumi_ready", 64'(fetch_ready_then_o), 64'd1);
        chk("after_yumi_fill", 64'(fill_count_o), 64'd3);
        yumi_cyc(); yumi_cyc(); yumi_cyc();
        chk("drained_empty", 64'(empty_o), 64'd1);

        // Steady state at occupancy 2
        cyc(1'b1, 32'h0000_0200, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0204, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h0000_0208 + 32'(4*i), 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
            chk("steady_fill", 64'(fill_count_o), 64'd2);
        end
        yumi_cyc(); yumi_cyc();
        chk("steady_empty", 64'(empty_o), 64'd1);

        // Flush with 3 entries, concurrent enqueue and yumi
        cyc(1'b1, 32'h0000_0300, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0304, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0308, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_fill", 64'(fill_count_o), 64'd3);
        sb.delete();
        cyc(1'b1, 32'h0000_030C, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("flush_empty", 64'(empty_o), 64'd1);
        chk("flush_issue_v", 64'(issue_v_o), 64'd0);
        chk("flush_next_pc_v", 64'(next_pc_v_o), 64'd0);
        chk("flush_next_pc_hold", 64'(next_pc_o), 64'h0000_030C);
        tick(); tick();
        chk("flush_still_empty", 64'(fill_count_o), 64'd0);

        // vaddr wrap, count/partial forwarded
        cyc(1'b1, 32'hFFFF_FFFE, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        chk("wrap_next_pc", 64'(next_pc_o), 64'h0000_0002);
        chk("wrap_count", 64'(issue_count_o), 64'd2);
        chk("wrap_partial", 64'(issue_partial_o), 64'd1);
        yumi_cyc();

        // Reset mid-operation zeroes next_pc as well
        cyc(1'b1, 32'h0000_0400, 32'h0000_0013, 32'h0000_0013, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        sb.delete();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("mid_rst_empty", 64'(empty_o), 64'd1);
        chk("mid_rst_next_pc", 64'(next_pc_o), 64'd0);
        chk("mid_rst_next_pc_v", 64'(next_pc_v_o), 64'd0);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_fe_fetch_queue.md
Name: bp_fe_fetch_queue

Overview:
- Consumer-side buffer for the realigner's fetch output interface (fetch_instr_v/pc/instr/count/partial, fetch_ready_then).
- Holds up to els_p fully assembled instructions and presents them one per cycle to the backend issue path using a valid/yumi handshake.
- Drives the ready_then signal back to the realigner.
- Tracks the sequential next-PC after the last enqueued instruction, and clears everything on a backend flush.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p, instr_width_gp (32), cinstr_width_gp (16), fetch_ptr_gp (2).
- els_p, 4, queue depth in instructions; must be a power of 2 and ≥2.
- lg_els_lp, $clog2(els_p), pointer width (derived, not overridable).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- fetch_instr_v_i  in  1  realigner presents one instruction this cycle
- fetch_pc_i  in  vaddr_width_p  PC of the presented instruction
- fetch_instr_i  in  instr_width_gp  instruction; compressed ones occupy [15:0], upper half don't-care
- fetch_count_i  in  fetch_ptr_gp  halfwords consumed from the IF2 line; stored and forwarded only
- fetch_partial_i  in  1  instruction was assembled from two fetch lines
- fetch_ready_then_o  out  1  queue can accept; valid may follow in the same cycle
- flush_i  in  1  backend redirect; discard all contents
- issue_v_o  out  1  head entry valid
- issue_pc_o  out  vaddr_width_p  head PC
- issue_instr_o  out  instr_width_gp  head instruction; upper 16 bits forced to 0 when compressed
- issue_compressed_o  out  1  head is a 16-bit instruction, i.e. ~&instr[1:0]
- issue_count_o  out  fetch_ptr_gp  head's stored fetch_count
- issue_partial_o  out  1  head's stored fetch_partial
- issue_yumi_i  in  1  backend consumes the head; legal only when issue_v_o
- empty_o  out  1  occupancy == 0
- fill_count_o  out  $clog2(els_p+1)  current occupancy
- next_pc_v_o  out  1  next_pc_o is meaningful
- next_pc_o  out  vaddr_width_p  PC immediately following the last enqueued instruction

Behaviour:
- Storage:
  - Circular buffer with rd_ptr and wr_ptr (lg_els_lp bits, wrap modulo els_p) and an occupancy counter.
  - Entry fields: {pc, instr, compressed, count, partial}.
  - compressed is computed at enqueue from fetch_instr_i[1:0].
- Reset:
  - All pointers, occupancy, next_pc_v and next_pc reset to 0.
  - Outputs after reset: issue_v_o=0, empty_o=1, fill_count_o=0, fetch_ready_then_o=1.
  - Entry data contents are not reset.
- fetch_ready_then_o = ~full, derived only from registered occupancy. There is no same-cycle dequeue credit: a full queue drops ready even when issue_yumi_i=1.
- Enqueue occurs when fetch_instr_v_i & fetch_ready_then_o & ~flush_i.
  - fetch_instr_v_i while not ready is a protocol violation (assertion); the input is ignored.
- Dequeue occurs when issue_yumi_i, which is only legal with issue_v_o (assertion).
- Latency: an enqueued instruction appears at issue_v_o the following cycle. There is no combinational bypass from fetch inputs to issue outputs.
- Issue outputs are driven from the entry at rd_ptr; issue_v_o = ~empty.
- Simultaneous enqueue and dequeue: occupancy unchanged, both pointers advance.
- next_pc update on each enqueue: next_pc ← fetch_pc_i + (compressed ? 2 : 4), computed in vaddr_width_p bits with wrap, and next_pc_v ← 1.
  - next_pc is unaffected by dequeue.
- Flush:
  - Next cycle: pointers = 0, occupancy = 0, next_pc_v = 0; next_pc holds its old value.
  - Same-cycle enqueue and yumi are discarded; flush has priority over both.
  - fetch_ready_then_o is not gated by flush_i in the flush cycle.
- Reset asserted mid-operation behaves identically to flush, and also zeroes next_pc.
- fill_count_o is full width, so els_p is representable.

Test Plan:
- Reset, then enqueue aligned 32-bit 0x00000013 at pc 0x80000000 → next cycle issue_v_o=1, pc 0x80000000, compressed=0, next_pc_o=0x80000004.
- Enqueue compressed 0x????4501 at pc 0x80000006 → issue_instr_o=0x00004501, compressed=1, next_pc_o=0x80000008.
- Enqueue 4 instructions with no yumi → fill_count_o=4, fetch_ready_then_o=0; a 5th valid is ignored and asserts; one yumi → ready returns the next cycle, and order is preserved across the wrap.
- Enqueue and yumi every cycle with occupancy held at 2 for 10 cycles → fill_count_o stays 2; issue PCs are sequential.
- With 3 entries, assert flush_i together with fetch_instr_v_i and issue_yumi_i → next cycle empty_o=1, next_pc_v_o=0, and the flushed-cycle instruction never issues.
- Enqueue at pc 0xFFFF_FFFE (vaddr wrap width) → next_pc_o wraps to 0x2 modulo 2^vaddr_width_p; partial=1 and count=2 are forwarded unchanged.
